// File: rtl/acc_pkg.sv
// Shared types and constants for the column-accumulator bank and its drain FSM.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      WRITE  = 2'd2,
      DRAIN  = 2'd3
   } acc_state_e;

   localparam logic MODE_ROWSUM = 1'b0;
   localparam logic MODE_COLUMN = 1'b1;

endpackage

// File: rtl/acc_bank_drain_if.sv
// Output-buffer write port of the accumulator bank.
interface acc_bank_drain_if #(
   parameter int ACC_BW = 32,
   parameter int ADDR_W = 4
);
   // Valid/ready: a word transfers on a rising edge where output_buffer_enable
   // and output_buffer_ready are both high; while enable is high and ready is
   // low, data and address stay stable and enable is not withdrawn.
   logic [ACC_BW-1:0] output_data;
   logic [ADDR_W-1:0] output_buffer_addr;
   logic              output_buffer_enable;
   logic              output_buffer_ready;

   modport master (
      output output_data,
      output output_buffer_addr,
      output output_buffer_enable,
      input  output_buffer_ready
   );

   modport slave (
      input  output_data,
      input  output_buffer_addr,
      input  output_buffer_enable,
      output output_buffer_ready
   );
endinterface

// File: rtl/acc_lane.sv
// One accumulator column: sign-extend, optional clear, add, and a snapshot
// register that captures the pre-clear running sum.
module acc_lane #(
   parameter int VERTICAL_BW = 32,
   parameter int ACC_BW      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          acc_reset,
   input  logic                          snap_en,
   input  logic signed [VERTICAL_BW-1:0] lane_in,
   output logic        [ACC_BW-1:0]      snap_next,
   output logic        [ACC_BW-1:0]      snap
);

   logic [ACC_BW-1:0] acc;
   logic [ACC_BW-1:0] add_val;

   assign add_val   = in_valid ? ACC_BW'(lane_in) : '0;
   // Snapshot ignores acc_reset so the last partial sum of a tile survives the clear.
   assign snap_next = acc + add_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc  <= '0;
         snap <= '0;
      end else begin
         acc <= (acc_reset ? '0 : acc) + add_val;
         if (snap_en) snap <= snap_next;
      end
   end

endmodule

// File: rtl/acc_bank_drain.sv
// Column-accumulator bank with snapshot and row-sum / per-column drain FSM.
import acc_pkg::*;

module acc_bank_drain #(
   parameter int ARR_SIZE    = 4,
   parameter int VERTICAL_BW = 32,
   parameter int ACC_BW      = 32,
   parameter int ADDR_W      = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [ARR_SIZE*VERTICAL_BW-1:0] accumulated_val,
   input  logic                            acc_reset,
   input  logic                            store_output,
   input  logic                            store_mode,
   input  logic [ADDR_W-1:0]               op_buffer_address,
   output logic                            store_ready,
   output logic [1:0]                      state_dbg,
   acc_bank_drain_if.master                obuf
);

   localparam int IDX_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_SIZE - 1);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_REDUCE = REDUCE;
   localparam logic [1:0] S_WRITE  = WRITE;
   localparam logic [1:0] S_DRAIN  = DRAIN;

   logic [1:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic [ADDR_W-1:0] base_addr;
   logic [ACC_BW-1:0] row_sum;
   logic              store_take;

   logic [ACC_BW-1:0] snap      [ARR_SIZE];
   logic [ACC_BW-1:0] snap_next [ARR_SIZE];

   assign store_ready = (state == S_IDLE);
   assign state_dbg   = state;
   assign store_take  = store_output && store_ready;
   assign idx_nxt     = idx + IDX_W'(1);

   for (genvar g = 0; g < ARR_SIZE; g++) begin : g_lane
      acc_lane #(
         .VERTICAL_BW (VERTICAL_BW),
         .ACC_BW      (ACC_BW)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .acc_reset (acc_reset),
         .snap_en   (store_take),
         .lane_in   (accumulated_val[g*VERTICAL_BW +: VERTICAL_BW]),
         .snap_next (snap_next[g]),
         .snap      (snap[g])
      );
   end

   // Single-cycle reduction of the latched snapshot, wrapping at ACC_BW.
   always_comb begin
      row_sum = '0;
      for (int k = 0; k < ARR_SIZE; k++) row_sum = row_sum + snap[k];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                     <= S_IDLE;
         idx                       <= '0;
         base_addr                 <= '0;
         obuf.output_data          <= '0;
         obuf.output_buffer_addr   <= '0;
         obuf.output_buffer_enable <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (store_take) begin
                  base_addr <= op_buffer_address;
                  if (store_mode == MODE_COLUMN) begin
                     // Column word 0 comes straight from the lane so it is valid one edge earlier.
                     obuf.output_data          <= snap_next[0];
                     obuf.output_buffer_addr   <= op_buffer_address;
                     obuf.output_buffer_enable <= 1'b1;
                     idx                       <= '0;
                     state                     <= S_DRAIN;
                  end else begin
                     state <= S_REDUCE;
                  end
               end
            end
            S_REDUCE: begin
               obuf.output_data          <= row_sum;
               obuf.output_buffer_addr   <= base_addr;
               obuf.output_buffer_enable <= 1'b1;
               state                     <= S_WRITE;
            end
            S_WRITE: begin
               if (obuf.output_buffer_ready) begin
                  obuf.output_buffer_enable <= 1'b0;
                  state                     <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (obuf.output_buffer_ready) begin
                  if (idx == LAST_IDX) begin
                     obuf.output_buffer_enable <= 1'b0;
                     state                     <= S_IDLE;
                  end else begin
                     idx                     <= idx_nxt;
                     obuf.output_data        <= snap[idx_nxt];
                     obuf.output_buffer_addr <= obuf.output_buffer_addr + ADDR_W'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_bank_drain.sv
// Bench for acc_bank_drain: directed scenarios plus random traffic against a
// transaction-level model of the lanes and the expected output-buffer writes.
module tb_acc_bank_drain;

   localparam int ARR_SIZE = 4;
   localparam int VBW      = 32;
   localparam int ACC_BW   = 32;
   localparam int ADDR_W   = 4;
   localparam int WW       = ADDR_W + ACC_BW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic                       in_valid = 1'b0;
   logic [ARR_SIZE*VBW-1:0]    accumulated_val = '0;
   logic                       acc_reset = 1'b0;
   logic                       store_output = 1'b0;
   logic                       store_mode = 1'b0;
   logic [ADDR_W-1:0]          op_buffer_address = '0;
   logic                       store_ready;
   logic [1:0]                 state_dbg;

   acc_bank_drain_if #(.ACC_BW(ACC_BW), .ADDR_W(ADDR_W)) obuf ();

   acc_bank_drain #(
      .ARR_SIZE    (ARR_SIZE),
      .VERTICAL_BW (VBW),
      .ACC_BW      (ACC_BW),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .accumulated_val   (accumulated_val),
      .acc_reset         (acc_reset),
      .store_output      (store_output),
      .store_mode        (store_mode),
      .op_buffer_address (op_buffer_address),
      .store_ready       (store_ready),
      .state_dbg         (state_dbg),
      .obuf              (obuf)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [ACC_BW-1:0] m_acc [ARR_SIZE];
   logic [WW-1:0]     exp_q [$];
   logic [WW-1:0]     obs_q [$];
   int                pending = 0;
   int                delay   = 0;
   int                en_cycles = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < ARR_SIZE; k++) m_acc[k] = '0;
      exp_q.delete();
      pending = 0;
      delay   = 0;
   endfunction

   // Transaction model: a store turns into a list of expected writes; the
   // bank is busy while any of them is outstanding (row-sum adds one cycle).
   function automatic void model_step();
      logic [ACC_BW-1:0] add [ARR_SIZE];
      logic [ACC_BW-1:0] s;
      logic [ACC_BW-1:0] sum;
      logic [ADDR_W-1:0] a;
      bit                idle_pre;
      idle_pre = (pending == 0 && delay == 0);
      if (pending > 0 && delay == 0 && obuf.output_buffer_ready) begin
         exp_q.delete(0);
         pending--;
      end else if (delay > 0) begin
         delay--;
      end
      for (int k = 0; k < ARR_SIZE; k++)
         add[k] = in_valid ? ACC_BW'(signed'(accumulated_val[k*VBW +: VBW])) : '0;
      if (store_output && idle_pre) begin
         sum = '0;
         for (int k = 0; k < ARR_SIZE; k++) begin
            s   = m_acc[k] + add[k];
            sum = sum + s;
            a   = op_buffer_address + ADDR_W'(k);
            if (store_mode) exp_q.push_back({a, s});
         end
         if (store_mode) begin
            pending = ARR_SIZE;
         end else begin
            exp_q.push_back({op_buffer_address, sum});
            pending = 1;
            delay   = 1;
         end
      end
      for (int k = 0; k < ARR_SIZE; k++)
         m_acc[k] = (acc_reset ? '0 : m_acc[k]) + add[k];
   endfunction

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_clear();
         else model_step();
      end
   end

   // Compare process: outputs against the model on every cycle out of reset.
   initial begin
      bit m_en;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_en = (pending > 0 && delay == 0);
            check("store_ready", 64'(store_ready), 64'(pending == 0 && delay == 0));
            check("enable", 64'(obuf.output_buffer_enable), 64'(m_en));
            if (m_en && exp_q.size() > 0)
               check("write", 64'({obuf.output_buffer_addr, obuf.output_data}), 64'(exp_q[0]));
            if (obuf.output_buffer_enable) en_cycles++;
            if (obuf.output_buffer_enable && obuf.output_buffer_ready)
               obs_q.push_back({obuf.output_buffer_addr, obuf.output_data});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input logic [VBW-1:0] l0, l1, l2, l3);
      accumulated_val = {l3, l2, l1, l0};
   endtask

   task automatic do_store(input logic mode, input logic [ADDR_W-1:0] base);
      store_output      = 1'b1;
      store_mode        = mode;
      op_buffer_address = base;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(store_ready && !obuf.output_buffer_enable) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("idle_timeout", 64'(n), 64'(0));
   endtask

   task automatic check_reset_outputs();
      check("rst_enable", 64'(obuf.output_buffer_enable), 64'(0));
      check("rst_data", 64'(obuf.output_data), 64'(0));
      check("rst_addr", 64'(obuf.output_buffer_addr), 64'(0));
      check("rst_store_ready", 64'(store_ready), 64'(1));
   endtask

   task automatic check_obs(input int i, input logic [ADDR_W-1:0] a, input logic [ACC_BW-1:0] d);
      if (obs_q.size() > i) check($sformatf("obs%0d", i), 64'(obs_q[i]), 64'({a, d}));
      else check($sformatf("obs%0d_missing", i), 64'(obs_q.size()), 64'(i + 1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      obuf.output_buffer_ready = 1'b1;
      repeat (2) tick();
      check_reset_outputs();
      rst = 1'b1;
      tick();

      // Row-sum of two beats of {1,2,3,4} -> 20 at address 5.
      in_valid = 1'b1;
      set_lanes(1, 2, 3, 4);
      tick();
      tick();
      in_valid = 1'b0;
      do_store(1'b0, 4'd5);
      obs_q.delete();
      en_cycles = 0;
      tick();
      store_output = 1'b0;
      wait_idle(20);
      check("rowsum_count", 64'(obs_q.size()), 64'(1));
      check_obs(0, 4'd5, 32'd20);
      check("rowsum_en_cycles", 64'(en_cycles), 64'(1));

      // Column drain with two stall cycles on the first word, address wrap.
      acc_reset = 1'b1;
      in_valid  = 1'b1;
      set_lanes(10, -3, 7, 0);
      tick();
      acc_reset = 1'b0;
      in_valid  = 1'b0;
      do_store(1'b1, 4'd14);
      obuf.output_buffer_ready = 1'b0;
      obs_q.delete();
      en_cycles = 0;
      tick();
      store_output = 1'b0;
      tick();
      tick();
      obuf.output_buffer_ready = 1'b1;
      wait_idle(20);
      check_obs(0, 4'd14, 32'd10);
      check_obs(1, 4'd15, 32'hFFFF_FFFD);
      check_obs(2, 4'd0, 32'd7);
      check_obs(3, 4'd1, 32'd0);
      check("stall_en_cycles", 64'(en_cycles), 64'(6));

      // Store, clear and last beat in one cycle; a store during drain is dropped.
      acc_reset = 1'b1;
      in_valid  = 1'b1;
      set_lanes(5, 5, 5, 5);
      tick();
      set_lanes(1, 1, 1, 1);
      do_store(1'b1, 4'd0);
      obs_q.delete();
      tick();
      acc_reset = 1'b0;
      in_valid  = 1'b0;
      do_store(1'b0, 4'd9);
      tick();
      store_output = 1'b0;
      wait_idle(20);
      check("overlap_count", 64'(obs_q.size()), 64'(4));
      for (int k = 0; k < ARR_SIZE; k++) check_obs(k, ADDR_W'(k), 32'd6);
      do_store(1'b0, 4'd3);
      obs_q.delete();
      tick();
      store_output = 1'b0;
      wait_idle(20);
      check_obs(0, 4'd3, 32'd4);

      // Lane overflow wraps to the most negative value; row-sum wraps too.
      acc_reset = 1'b1;
      in_valid  = 1'b1;
      set_lanes(32'h7FFF_FFFF, 0, 0, 0);
      tick();
      acc_reset = 1'b0;
      set_lanes(1, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      do_store(1'b1, 4'd0);
      obs_q.delete();
      tick();
      store_output = 1'b0;
      wait_idle(20);
      check_obs(0, 4'd0, 32'h8000_0000);
      acc_reset = 1'b1;
      in_valid  = 1'b1;
      set_lanes(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      tick();
      acc_reset = 1'b0;
      in_valid  = 1'b0;
      do_store(1'b0, 4'd7);
      obs_q.delete();
      tick();
      store_output = 1'b0;
      wait_idle(20);
      check_obs(0, 4'd7, 32'hFFFF_FFFC);

      // Reset in the middle of a column drain, after two words.
      acc_reset = 1'b1;
      in_valid  = 1'b1;
      set_lanes(11, 22, 33, 44);
      tick();
      acc_reset = 1'b0;
      in_valid  = 1'b0;
      do_store(1'b1, 4'd2);
      obs_q.delete();
      tick();
      store_output = 1'b0;
      n = 0;
      while (obs_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      rst = 1'b0;
      #1;
      check_reset_outputs();
      tick();
      rst = 1'b1;
      repeat (5) tick();
      check("rst_drain_words", 64'(obs_q.size()), 64'(2));
      check_obs(0, 4'd2, 32'd11);
      check_obs(1, 4'd3, 32'd22);
      do_store(1'b0, 4'd1);
      obs_q.delete();
      tick();
      store_output = 1'b0;
      wait_idle(20);
      check_obs(0, 4'd1, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         acc_reset = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) != 0)
            set_lanes($urandom(), $urandom(), $urandom(), $urandom());
         else
            set_lanes($urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10,
                      $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10);
         store_output             = ($urandom_range(0, 3) == 0);
         store_mode               = 1'($urandom_range(0, 1));
         op_buffer_address        = ADDR_W'($urandom_range(0, 15));
         obuf.output_buffer_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      store_output             = 1'b0;
      in_valid                 = 1'b0;
      acc_reset                = 1'b0;
      obuf.output_buffer_ready = 1'b1;
      wait_idle(50);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
